// File: rtl/victim_wb_ctrl_pkg.sv
// rtl/victim_wb_ctrl_pkg.sv - shared line geometry constants and writeback FSM state type
package victim_wb_ctrl_pkg;

    localparam int LINE_BITS   = 512;
    localparam int TAG_BITS    = 26;
    localparam int WORD_BITS   = 32;
    localparam int BEATS       = 16;
    localparam int OFFSET_BITS = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wb_state_e;

endpackage

// File: rtl/wb_line_fifo.sv
// rtl/wb_line_fifo.sv - dirty-line writeback FIFO with associative tag lookup over occupied entries
module wb_line_fifo
    import victim_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push,
    input  logic [TAG_BITS-1:0]  push_tag,
    input  logic [LINE_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [TAG_BITS-1:0]  head_tag,
    output logic [LINE_BITS-1:0] head_data,
    output logic                 full,
    output logic                 empty,
    input  logic [TAG_BITS-1:0]  chk_tag,
    output logic                 chk_hit,
    output logic [LINE_BITS-1:0] chk_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_BITS-1:0]  tag_mem  [DEPTH];
    logic [LINE_BITS-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]     head_ptr;
    logic [PTR_W-1:0]     tail_ptr;
    logic [CNT_W-1:0]     count;
    logic [PTR_W-1:0]     idx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + PTR_W'(1);
            if (pop)  head_ptr <= head_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry contents carry no reset; occupancy is defined purely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[tail_ptr]  <= push_tag;
            data_mem[tail_ptr] <= push_data;
        end
    end

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_tag  = tag_mem[head_ptr];
    assign head_data = data_mem[head_ptr];

    // Walk oldest to newest so the last match seen is the newest copy of the line.
    always_comb begin
        chk_hit  = 1'b0;
        chk_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (tag_mem[idx] == chk_tag)) begin
                chk_hit  = 1'b1;
                chk_data = data_mem[idx];
            end
        end
    end

endmodule

// File: rtl/victim_wb_ctrl.sv
// rtl/victim_wb_ctrl.sv - victim cache fill and dirty-line burst writeback controller
module victim_wb_ctrl
    import victim_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int BEATS = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 ev_valid,
    output logic                 ev_ready,
    input  logic [TAG_BITS-1:0]  ev_tag,
    input  logic [LINE_BITS-1:0] ev_data,
    input  logic                 ev_dirty,
    output logic                 vc_we,
    output logic [TAG_BITS-1:0]  vc_w_tag,
    output logic [LINE_BITS-1:0] vc_data_in,
    input  logic [TAG_BITS-1:0]  chk_tag,
    output logic                 chk_hit,
    output logic [LINE_BITS-1:0] chk_data,
    output logic                 aw_valid,
    input  logic                 aw_ready,
    output logic [31:0]          aw_addr,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [WORD_BITS-1:0] w_data,
    output logic                 w_last,
    input  logic                 b_valid,
    output logic                 b_ready
);

    localparam int BEAT_W = $clog2(BEATS);

    wb_state_e             state;
    wb_state_e             state_nxt;
    logic [BEAT_W-1:0]     beat;
    logic [BEAT_W-1:0]     beat_nxt;
    logic                  ev_fire;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [TAG_BITS-1:0]   head_tag;
    logic [LINE_BITS-1:0]  head_data;

    assign ev_ready = !full;
    assign ev_fire  = ev_valid && ev_ready;
    assign push     = ev_fire && ev_dirty;

    wb_line_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_tag  (ev_tag),
        .push_data (ev_data),
        .pop       (pop),
        .head_tag  (head_tag),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .chk_tag   (chk_tag),
        .chk_hit   (chk_hit),
        .chk_data  (chk_data)
    );

    // Every accepted eviction, clean or dirty, lands in the victim cache one cycle later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) vc_we <= 1'b0;
        else       vc_we <= ev_fire;
    end

    always_ff @(posedge clk) begin
        if (ev_fire) begin
            vc_w_tag   <= ev_tag;
            vc_data_in <= ev_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    // Head entry stays put until the response pops it, so address and data hold under stall.
    assign aw_addr = {head_tag, {OFFSET_BITS{1'b0}}};
    assign w_data  = head_data[int'(beat)*WORD_BITS +: WORD_BITS];

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        w_last    = 1'b0;
        b_ready   = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) state_nxt = ADDR;
            end
            ADDR: begin
                aw_valid = 1'b1;
                if (aw_ready) state_nxt = DATA;
            end
            DATA: begin
                w_valid = 1'b1;
                w_last  = (beat == BEAT_W'(BEATS - 1));
                if (w_ready) begin
                    if (w_last) begin
                        beat_nxt  = '0;
                        state_nxt = RESP;
                    end else begin
                        beat_nxt = beat + BEAT_W'(1);
                    end
                end
            end
            RESP: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_victim_wb_ctrl.sv
// tb/tb_victim_wb_ctrl.sv - randomized self-checking bench for victim_wb_ctrl against a queue model
module tb_victim_wb_ctrl;
    import victim_wb_ctrl_pkg::*;

    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 ev_valid;
    logic                 ev_ready;
    logic [TAG_BITS-1:0]  ev_tag;
    logic [LINE_BITS-1:0] ev_data;
    logic                 ev_dirty;
    logic                 vc_we;
    logic [TAG_BITS-1:0]  vc_w_tag;
    logic [LINE_BITS-1:0] vc_data_in;
    logic [TAG_BITS-1:0]  chk_tag;
    logic                 chk_hit;
    logic [LINE_BITS-1:0] chk_data;
    logic                 aw_valid;
    logic                 aw_ready;
    logic [31:0]          aw_addr;
    logic                 w_valid;
    logic                 w_ready;
    logic [WORD_BITS-1:0] w_data;
    logic                 w_last;
    logic                 b_valid;
    logic                 b_ready;

    always #5 clk = ~clk;

    victim_wb_ctrl #(.DEPTH(DEPTH), .BEATS(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_tag     (ev_tag),
        .ev_data    (ev_data),
        .ev_dirty   (ev_dirty),
        .vc_we      (vc_we),
        .vc_w_tag   (vc_w_tag),
        .vc_data_in (vc_data_in),
        .chk_tag    (chk_tag),
        .chk_hit    (chk_hit),
        .chk_data   (chk_data),
        .aw_valid   (aw_valid),
        .aw_ready   (aw_ready),
        .aw_addr    (aw_addr),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .w_last     (w_last),
        .b_valid    (b_valid),
        .b_ready    (b_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: pending dirty lines in order, plus progress of the head's burst.
    logic [TAG_BITS-1:0]  m_tag  [$];
    logic [LINE_BITS-1:0] m_data [$];
    bit                   m_aw_done;
    int                   m_beats;
    bit                   exp_vc_we;
    logic [TAG_BITS-1:0]  exp_vc_tag;
    logic [LINE_BITS-1:0] exp_vc_data;
    bit                   prev_aw_stall;
    bit                   prev_w_stall;
    bit                   prev_b_hs;
    int                   idle_run;
    int                   wb_done;
    int                   mem_mode;

    always @(negedge clk) begin
        logic                 exp_hit;
        logic [LINE_BITS-1:0] exp_cd;
        logic [LINE_BITS-1:0] cur;
        bit                   fire;
        if (!rstn) begin
            check_eq("rst_vc_we", vc_we, 0);
            check_eq("rst_aw_valid", aw_valid, 0);
            check_eq("rst_w_valid", w_valid, 0);
            check_eq("rst_w_last", w_last, 0);
            check_eq("rst_b_ready", b_ready, 0);
            check_eq("rst_chk_hit", chk_hit, 0);
            m_tag.delete();
            m_data.delete();
            m_aw_done     = 0;
            m_beats       = 0;
            exp_vc_we     = 0;
            prev_aw_stall = 0;
            prev_w_stall  = 0;
            prev_b_hs     = 0;
            idle_run      = 0;
        end else begin
            check_eq("ev_ready", ev_ready, m_tag.size() < DEPTH);
            check_eq("vc_we", vc_we, exp_vc_we);
            if (exp_vc_we) begin
                check_eq("vc_w_tag", vc_w_tag, exp_vc_tag);
                check_eq("vc_data_in", vc_data_in, exp_vc_data);
            end
            exp_hit = 0;
            exp_cd  = '0;
            foreach (m_tag[i]) begin
                if (m_tag[i] == chk_tag) begin
                    exp_hit = 1;
                    exp_cd  = m_data[i];
                end
            end
            check_eq("chk_hit", chk_hit, exp_hit);
            if (exp_hit) check_eq("chk_data", chk_data, exp_cd);
            if (prev_aw_stall) check_eq("aw_hold", aw_valid, 1);
            if (prev_w_stall)  check_eq("w_hold", w_valid, 1);
            if (prev_b_hs)     check_eq("idle_gap", aw_valid, 0);
            check_eq("one_channel", int'(aw_valid) + int'(w_valid) + int'(b_ready) <= 1, 1);
            if (aw_valid) begin
                check_eq("aw_pending", (m_tag.size() > 0) && !m_aw_done, 1);
                if (m_tag.size() > 0) check_eq("aw_addr", aw_addr, {m_tag[0], 6'b0});
            end
            if (w_valid) begin
                check_eq("w_order", m_aw_done && (m_beats < 16), 1);
                if ((m_tag.size() > 0) && (m_beats < 16)) begin
                    cur = m_data[0];
                    check_eq("w_data", w_data, cur[m_beats*32 +: 32]);
                    check_eq("w_last", w_last, m_beats == 15);
                end
            end
            if (b_ready) check_eq("b_ready", m_beats == 16, 1);
            if ((m_tag.size() > 0) && !aw_valid && !w_valid && !b_ready) idle_run++;
            else idle_run = 0;
            if (idle_run > 1) check_eq("stall", idle_run, 1);

            prev_aw_stall = aw_valid && !aw_ready;
            prev_w_stall  = w_valid && !w_ready;
            prev_b_hs     = b_ready && b_valid;
            fire          = ev_valid && (m_tag.size() < DEPTH);
            exp_vc_we     = fire;
            if (fire) begin
                exp_vc_tag  = ev_tag;
                exp_vc_data = ev_data;
            end
            if (aw_valid && aw_ready) m_aw_done = 1;
            if (w_valid && w_ready && m_beats < 16) m_beats++;
            if (b_ready && b_valid && m_tag.size() > 0) begin
                void'(m_tag.pop_front());
                void'(m_data.pop_front());
                m_aw_done = 0;
                m_beats   = 0;
                wb_done++;
            end
            if (fire && ev_dirty) begin
                m_tag.push_back(ev_tag);
                m_data.push_back(ev_data);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (mem_mode)
            0: begin aw_ready = 1; w_ready = 1; b_valid = 1; end
            1: begin
                aw_ready = 1'($urandom_range(0, 1));
                w_ready  = 1'($urandom_range(0, 1));
                b_valid  = 1'($urandom_range(0, 1));
            end
            2: begin aw_ready = 1; w_ready = ~w_ready; b_valid = 1; end
            default: begin aw_ready = 0; w_ready = 1; b_valid = 1; end
        endcase
        if ((m_tag.size() > 0) && ($urandom_range(0, 3) != 0))
            chk_tag = m_tag[$urandom_range(0, m_tag.size() - 1)];
        else
            chk_tag = 26'($urandom_range(0, 7));
    end

    function automatic logic [LINE_BITS-1:0] rand_line();
        logic [LINE_BITS-1:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic offer(input logic [TAG_BITS-1:0] t, input logic [LINE_BITS-1:0] d, input bit dirty);
        int n = 0;
        bit done = 0;
        @(posedge clk); #1;
        ev_valid = 1; ev_tag = t; ev_data = d; ev_dirty = dirty;
        while (!done && n < 200) begin
            @(negedge clk);
            if (ev_ready) done = 1;
            n++;
        end
        check_eq("offer_accept", done, 1);
        @(posedge clk); #1;
        ev_valid = 0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (m_tag.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq("drain", m_tag.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [LINE_BITS-1:0] d;
        int n;
        rstn = 0; ev_valid = 0; ev_tag = '0; ev_data = '0; ev_dirty = 0;
        chk_tag = '0; aw_ready = 0; w_ready = 0; b_valid = 0;
        mem_mode = 0; wb_done = 0;
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        @(negedge clk);
        check_eq("rel_ev_ready", ev_ready, 1);

        // Single dirty line with a counting word pattern
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = i;
        offer(26'h0012345, d, 1);
        drain(200);
        check_eq("wb_count_1", wb_done, 1);

        // Clean eviction never reaches memory
        offer(26'h3, rand_line(), 0);
        repeat (4) begin
            @(negedge clk);
            check_eq("clean_no_aw", aw_valid, 0);
            check_eq("clean_ev_ready", ev_ready, 1);
        end
        check_eq("wb_count_clean", wb_done, 1);

        // Fill the FIFO while the address channel is blocked
        mem_mode = 3;
        for (int i = 0; i < 4; i++) offer(26'(i + 1), rand_line(), 1);
        @(negedge clk);
        check_eq("full_ev_ready", ev_ready, 0);
        @(posedge clk); #1;
        ev_valid = 1; ev_tag = 26'h5; ev_data = rand_line(); ev_dirty = 1;
        repeat (5) begin
            @(negedge clk);
            check_eq("fifth_held", ev_ready, 0);
        end
        mem_mode = 0;
        n = 0;
        while (!ev_ready && n < 200) begin @(negedge clk); n++; end
        check_eq("fifth_accept", ev_ready, 1);
        @(posedge clk); #1;
        ev_valid = 0;
        drain(400);
        check_eq("wb_count_full", wb_done, 6);

        // Alternating write-data stalls
        mem_mode = 2;
        offer(26'h2A, rand_line(), 1);
        drain(200);
        check_eq("wb_count_toggle", wb_done, 7);

        // Random traffic with repeated tags and random memory backpressure
        mem_mode = 1;
        repeat (600) begin
            @(posedge clk); #1;
            ev_valid = 1'($urandom_range(0, 2) == 0);
            ev_tag   = 26'($urandom_range(0, 7));
            ev_data  = rand_line();
            ev_dirty = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        ev_valid = 0;
        drain(2000);

        // Reset in the middle of a burst with another line queued behind it
        mem_mode = 0;
        offer(26'h11, rand_line(), 1);
        offer(26'h12, rand_line(), 1);
        n = 0;
        while (!(w_valid && m_beats == 7) && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq("reach_beat7", w_valid && (m_beats == 7), 1);
        rstn = 0;
        #1;
        check_eq("mid_rst_w_valid", w_valid, 0);
        check_eq("mid_rst_aw_valid", aw_valid, 0);
        check_eq("mid_rst_w_last", w_last, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        repeat (20) begin
            @(negedge clk);
            check_eq("post_rst_aw", aw_valid, 0);
            check_eq("post_rst_w", w_valid, 0);
            check_eq("post_rst_ev_ready", ev_ready, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
